square_sequencer: RTL

Iteration controller for the squaring datapath built around the column-compressed multiply array and its downstream reduction. It accepts a start command with an iteration count T and sequences T back-to-back squarings through the fixed-latency datapath. For each squaring it drives the datapath input-register load/select strobes, and after the last result it strobes the output-register capture and reports completion. It holds no operand data; it is pure control.

---
 rtl/square_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/square_sequencer.sv
// Control sequencer for the squaring datapath: issues T back-to-back squarings
// through a fixed-latency pipeline, then captures the result and signals done.
module square_sequencer #(
  parameter int PIPE_LAT = 8,
  parameter int ITER_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iterations,
  input  logic              abort,
  output logic              in_en,
  output logic              in_sel,
  output logic              out_en,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [7:0]        LAT_RELOAD = 8'(PIPE_LAT - 1);
  localparam logic [ITER_W-1:0] ONE        = ITER_W'(1);

  state_t            state, nxt_state;
  logic [7:0]        lat_cnt, nxt_lat;
  logic [ITER_W-1:0] t_reg, nxt_t, nxt_iter;
  logic              nxt_err, nxt_fire, nxt_last;

  // Strobes are registered, so they are derived from the state the machine is
  // about to enter rather than the state it is leaving.
  always_comb begin
    nxt_state = state;
    nxt_lat   = lat_cnt;
    nxt_t     = t_reg;
    nxt_iter  = iter_count;
    nxt_err   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (iterations != '0) begin
            nxt_t     = iterations;
            nxt_iter  = '0;
            nxt_state = LOAD;
          end else begin
            nxt_err = 1'b1;
          end
        end
      end
      LOAD: begin
        nxt_lat   = LAT_RELOAD;
        nxt_state = RUN;
      end
      RUN: begin
        if (lat_cnt != 8'd0) begin
          nxt_lat = lat_cnt - 8'd1;
        end else begin
          nxt_iter = iter_count + ONE;
          if (iter_count + ONE == t_reg) nxt_state = DONE;
          else                           nxt_lat   = LAT_RELOAD;
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    if (abort && state != IDLE) begin
      nxt_state = IDLE;
      nxt_iter  = iter_count;
    end
    nxt_fire = (nxt_state == RUN) && (nxt_lat == 8'd0);
    nxt_last = (nxt_iter + ONE == nxt_t);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 8'd0;
      t_reg      <= '0;
      iter_count <= '0;
      in_en      <= 1'b0;
      in_sel     <= 1'b0;
      out_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      lat_cnt    <= nxt_lat;
      t_reg      <= nxt_t;
      iter_count <= nxt_iter;
      in_en      <= (nxt_state == LOAD) || (nxt_fire && !nxt_last);
      in_sel     <= nxt_fire && !nxt_last;
      out_en     <= nxt_fire && nxt_last;
      done       <= (nxt_state == DONE);
      err        <= nxt_err;
      busy       <= (nxt_state != IDLE);
    end
  end

endmodule
